// File: rtl/ones_decoder.sv
// ones_decoder: streaming size/value (ones-complement) code decoder.
// MSB-first bit buffer in, one signed WIDTH-bit value out per request.
module ones_decoder #(
    parameter int WIDTH = 8,
    parameter int IN_W  = 16,
    parameter int BUF_W = 32,
    localparam int SW   = $clog2(WIDTH),
    localparam int CW   = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SW-1:0]    req_size,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [WIDTH-1:0] out_val,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    bits_avail
);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_n;
    logic [BUF_W-1:0] rem;
    logic [BUF_W-1:0] ins;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    s_ext;
    logic [CW-1:0]    pop_n;
    logic [CW-1:0]    keep;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] msb;
    logic [WIDTH-1:0] dec;
    logic             accept;
    logic             push;

    assign s_ext      = CW'(req_size);
    assign bits_avail = cnt_q;
    assign in_ready   = cnt_q <= CW'(BUF_W - IN_W);
    assign req_ready  = (!out_valid || out_ready)
                     && (cnt_q >= s_ext) && !flush;
    assign accept     = req_valid && req_ready;
    assign push       = in_valid && in_ready && !flush;
    assign pop_n      = accept ? s_ext : '0;
    assign keep       = cnt_q - pop_n;

    // Buffer is MSB-aligned with zeros below the valid bits.
    always_comb begin
        v     = WIDTH'(buf_q >> (CW'(BUF_W) - s_ext));
        mask  = (WIDTH'(1) << req_size) - WIDTH'(1);
        msb   = mask ^ (mask >> 1);
        dec   = ((v & msb) != '0) ? v : v - mask;
        rem   = buf_q << pop_n;
        ins   = BUF_W'(in_word) << (BUF_W - IN_W);
        buf_n = rem;
        cnt_n = keep;
        if (push) begin
            buf_n = rem | (ins >> keep);
            cnt_n = keep + CW'(IN_W);
        end
        if (flush) begin
            buf_n = '0;
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            out_val   <= '0;
            out_valid <= 1'b0;
        end else begin
            buf_q <= buf_n;
            cnt_q <= cnt_n;
            if (accept) begin
                out_val   <= dec;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ones_decoder.sv
// tb_ones_decoder: directed steps with a bit-queue reference model
// and an expected-value scoreboard for ones_decoder.
module tb_ones_decoder;

    localparam int WIDTH = 8;
    localparam int IN_W  = 16;
    localparam int BUF_W = 32;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  req_size;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  out_val;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [5:0]  bits_avail;

    int n_pass;
    int n_total;

    bit         mq[$];
    logic [7:0] exq[$];
    bit         mov;

    ones_decoder #(
        .WIDTH(WIDTH),
        .IN_W (IN_W),
        .BUF_W(BUF_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req_size  (req_size),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .bits_avail(bits_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, expv);
    endtask

    // Ones-complement magnitude: a leading 0 means the value is -(~v).
    function automatic logic [7:0] ref_dec(input logic [7:0] v,
                                           input int s);
        int r;
        int m;
        m = (1 << s) - 1;
        if (s == 0) r = 0;
        else if (v[s-1]) r = int'(v);
        else r = -(m ^ int'(v));
        return 8'(r);
    endfunction

    task automatic cyc();
        int n;
        bit mir;
        bit mrr;
        bit acc;
        logic [7:0] v;
        logic [7:0] e;
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
            exq.delete();
            mov = 1'b0;
        end else begin
            n   = mq.size();
            mir = (n <= BUF_W - IN_W);
            mrr = (!mov || out_ready)
               && (n >= int'(req_size)) && !flush;
            chk("bits_avail", 32'(bits_avail), n);
            chk("bits_bound", 32'(bits_avail <= 6'd32), 1);
            chk("in_ready", 32'(in_ready), 32'(mir));
            chk("req_ready", 32'(req_ready), 32'(mrr));
            chk("out_valid", 32'(out_valid), 32'(mov));
            if (mov) begin
                e = (exq.size() != 0) ? exq[0] : 8'hxx;
                chk("sb_out_val", 32'(out_val), 32'(e));
                if (out_ready && exq.size() != 0)
                    void'(exq.pop_front());
            end
            acc = req_valid && mrr;
            if (acc) begin
                v = '0;
                for (int i = 0; i < int'(req_size); i++)
                    v = {v[6:0], mq.pop_front()};
                exq.push_back(ref_dec(v, int'(req_size)));
            end
            if (flush) mq.delete();
            else if (in_valid && mir)
                for (int i = IN_W - 1; i >= 0; i--)
                    mq.push_back(in_word[i]);
            if (acc) mov = 1'b1;
            else if (out_ready) mov = 1'b0;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        mov       = 1'b0;
        rst_n     = 1'b0;
        in_word   = '0;
        in_valid  = 1'b0;
        req_size  = '0;
        req_valid = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        cyc();
        cyc();
        chk("rst_bits", 32'(bits_avail), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_val", 32'(out_val), 0);
        rst_n = 1'b1;
        cyc();
        chk("rel_in_ready", 32'(in_ready), 1);

        // decode +5, -13, 0, +124
        in_word = 16'hA5F0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        req_size = 3'd3; req_valid = 1'b1;
        cyc();
        chk("d3_val", 32'(out_val), 32'h05);
        chk("d3_bits", 32'(bits_avail), 13);
        req_size = 3'd4;
        cyc();
        chk("d4_val", 32'(out_val), 32'hF3);
        chk("d4_bits", 32'(bits_avail), 9);
        req_size = 3'd0;
        cyc();
        chk("d0_valid", 32'(out_valid), 1);
        chk("d0_val", 32'(out_val), 32'h00);
        chk("d0_bits", 32'(bits_avail), 9);
        req_size = 3'd7;
        cyc();
        chk("d7_val", 32'(out_val), 32'h7C);
        chk("d7_bits", 32'(bits_avail), 2);

        // starvation
        req_size = 3'd5;
        repeat (3) begin
            cyc();
            chk("starve_rdy", 32'(req_ready), 0);
        end
        in_word = 16'h8000; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("starve_go", 32'(req_ready), 1);
        cyc();
        chk("starve_val", 32'(out_val), 32'hE5);
        chk("starve_bits", 32'(bits_avail), 13);
        req_valid = 1'b0;

        // backpressure
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_word = 16'hA5F0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        req_size = 3'd3; req_valid = 1'b1;
        cyc();
        out_ready = 1'b0;
        req_size  = 3'd4;
        repeat (10) begin
            cyc();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_val", 32'(out_val), 32'h05);
            chk("bp_rdy", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(req_ready), 1);
        cyc();
        chk("bp_next_val", 32'(out_val), 32'hF3);
        chk("bp_next_bits", 32'(bits_avail), 9);
        req_valid = 1'b0;
        cyc();

        // fill and simultaneous push/pop
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_word = 16'hFFFF; in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("fill_bits", 32'(bits_avail), 32);
        chk("fill_in_ready", 32'(in_ready), 0);
        req_size = 3'd7; req_valid = 1'b1;
        cyc();
        chk("fill_val", 32'(out_val), 32'h7F);
        chk("fill_bits25", 32'(bits_avail), 25);
        cyc();
        chk("fill_bits18", 32'(bits_avail), 18);
        in_valid = 1'b1; req_size = 3'd2;
        cyc();
        req_valid = 1'b0;
        chk("sim_val", 32'(out_val), 32'h03);
        chk("sim_bits16", 32'(bits_avail), 16);
        cyc();
        in_valid = 1'b0;
        chk("sim_bits32", 32'(bits_avail), 32);

        // flush with a pending output
        req_size = 3'd7; req_valid = 1'b1;
        cyc();
        req_size = 3'd5;
        cyc();
        chk("pre_flush_bits", 32'(bits_avail), 20);
        chk("pre_flush_valid", 32'(out_valid), 1);
        req_valid = 1'b0; out_ready = 1'b0;
        flush = 1'b1; in_valid = 1'b1; in_word = 16'h1234;
        #1;
        chk("flush_req_rdy", 32'(req_ready), 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_bits", 32'(bits_avail), 0);
        chk("flush_hold_valid", 32'(out_valid), 1);
        chk("flush_hold_val", 32'(out_val), 32'h1F);
        out_ready = 1'b1;
        cyc();
        chk("flush_drained", 32'(out_valid), 0);
        flush = 1'b1; in_valid = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_push", 32'(bits_avail), 0);

        // asynchronous reset mid-stream
        in_word = 16'hA5F0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        req_size = 3'd3; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_bits", 32'(bits_avail), 0);
        chk("arst_val", 32'(out_val), 0);
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        in_word = 16'h4000; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        req_size = 3'd2; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("arst_after_val", 32'(out_val), 32'hFE);
        chk("arst_after_bits", 32'(bits_avail), 14);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
